// File: rtl/odd_parity_pkg.sv
// Shared definitions for the odd-parity checker scheduler.
//   state_t : checker FSM states
//   WORD_W  : width of one requester word (4 data bits + odd parity bit)
//   NREQ    : number of requesters
//   ID_W    : width of a requester index
package odd_parity_pkg;

    localparam int WORD_W = 5;
    localparam int NREQ   = 4;
    localparam int ID_W   = 2;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        REPORT
    } state_t;

endpackage

// File: rtl/odd_parity_sched_if.sv
// Requester/result bus of odd_parity_sched.
//   req       : per-requester level request
//   word      : packed requester words, requester i at [5i+4:5i]
//   err_clr   : synchronous clear of the error counter
//   ack       : one-hot result acknowledge pulse
//   grant     : one-hot current owner of the checker
//   busy      : checker not idle
//   res_valid : result strobe, with res_err / res_id
//   err_cnt   : saturating count of reported parity errors
interface odd_parity_sched_if #(
    parameter int CNT_W = 8
);
    import odd_parity_pkg::*;

    logic [NREQ-1:0]        req;
    logic [NREQ*WORD_W-1:0] word;
    logic                   err_clr;
    logic [NREQ-1:0]        ack;
    logic [NREQ-1:0]        grant;
    logic                   busy;
    logic                   res_valid;
    logic                   res_err;
    logic [ID_W-1:0]        res_id;
    logic [CNT_W-1:0]       err_cnt;

    modport master (
        output req, word, err_clr,
        input  ack, grant, busy, res_valid, res_err, res_id, err_cnt
    );

    modport slave (
        input  req, word, err_clr,
        output ack, grant, busy, res_valid, res_err, res_id, err_cnt
    );

endinterface

// File: rtl/odd_parity_check.sv
// Combinational odd-parity evaluator.
//   din : captured 5-bit word (data nibble + parity bit)
//   err : high when the number of ones in din is even
module odd_parity_check
    import odd_parity_pkg::*;
(
    input  logic [WORD_W-1:0] din,
    output logic              err
);

    assign err = ~(^din);

endmodule

// File: rtl/odd_parity_sched.sv
// Round-robin scheduler sharing one odd-parity checker among four requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of odd_parity_sched_if (requests/words in,
//                grant/ack/result/error count out)
// Each transaction takes IDLE -> CHECK -> REPORT; the result is presented
// for one cycle in REPORT and the pointer then moves past the winner.
module odd_parity_sched
    import odd_parity_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    odd_parity_sched_if.slave  bus
);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q,   ptr_d;
    logic [ID_W-1:0]   win_q,   win_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [WORD_W-1:0] word_q,  word_d;
    logic              err_q,   err_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic              par_err;
    logic [ID_W-1:0]   pick;

    // First requester found scanning ptr, ptr+1, ... (mod NREQ). Scanning
    // from the far end downward lets the nearest hit overwrite the others.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                input logic [ID_W-1:0] p);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] win;
        win = p;
        for (int unsigned k = NREQ; k > 0; k--) begin
            idx = p + ID_W'(k - 1);
            if (r[idx]) win = idx;
        end
        return win;
    endfunction

    assign pick = rr_pick(bus.req, ptr_q);

    odd_parity_check u_check (
        .din (word_q),
        .err (par_err)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        grant_d = grant_q;
        word_d  = word_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    win_d   = pick;
                    grant_d = NREQ'(1) << pick;
                    word_d  = bus.word[WORD_W*int'(pick) +: WORD_W];
                    state_d = CHECK;
                end
            end
            CHECK: begin
                err_d   = par_err;
                state_d = REPORT;
            end
            REPORT: begin
                ptr_d   = win_q + ID_W'(1);
                grant_d = '0;
                state_d = IDLE;
                if (err_q && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
        if (bus.err_clr) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            grant_q <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            grant_q <= grant_d;
            word_q  <= word_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result outputs are qualified by REPORT so they read zero elsewhere.
    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.res_valid = (state_q == REPORT);
    assign bus.res_err   = (state_q == REPORT) && err_q;
    assign bus.res_id    = (state_q == REPORT) ? win_q : '0;
    assign bus.ack       = (state_q == REPORT) ? grant_q : '0;
    assign bus.err_cnt   = cnt_q;

endmodule

// File: doc/odd_parity_sched.md
ODD_PARITY_SCHED -- requirements
Module: odd_parity_sched

Interface
REQ-001 Parameter: CNT_W, 8, width of the saturating error counter.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  per-requester check request, level, bit i = requester i.
REQ-005 Port: word  input  20  requester i word at bits [5i+4:5i]; [5i+3:5i] = data nibble, [5i+4] = odd parity bit.
REQ-006 Port: ack  output  4  one-hot, one-cycle pulse to the requester whose result is being reported.
REQ-007 Port: grant  output  4  one-hot, requester currently owning the checker; all-zero when idle.
REQ-008 Port: busy  output  1  high in any state other than IDLE.
REQ-009 Port: res_valid  output  1  one-cycle result strobe.
REQ-010 Port: res_err  output  1  parity error flag; valid only with res_valid.
REQ-011 Port: res_id  output  2  index of the requester the result belongs to; valid only with res_valid.
REQ-012 Port: err_clr  input  1  synchronous clear of err_cnt.
REQ-013 Port: err_cnt  output  CNT_W  saturating count of reported errors.

Function
REQ-014 FSM states SHALL be exactly IDLE, CHECK, REPORT.
REQ-015 IDLE: if req != 0, SHALL select the winner round-robin starting at pointer ptr, set grant one-hot, capture that requester's 5-bit word, go to CHECK; else stay in IDLE.
REQ-016 CHECK: SHALL compute err = NOT(XOR of all 5 captured bits), i.e. error when the number of ones is even, register it, go to REPORT.
REQ-017 REPORT: SHALL assert res_valid, res_err, res_id and ack[winner] for exactly one cycle, set ptr = winner+1 mod 4, go to IDLE.
REQ-018 Latency: req sampled high in IDLE at cycle N SHALL yield res_valid at cycle N+2; next grant at earliest N+3.
REQ-019 Round-robin: ptr SHALL hold the highest priority; search order ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-020 Data SHALL be captured only in IDLE; changes to word or deassertion of req during CHECK/REPORT SHALL NOT alter the pending result, which is still reported.
REQ-021 A requester keeping req high after ack SHALL be treated as a new request, arbitrated normally.
REQ-022 grant SHALL stay stable from the IDLE->CHECK edge through REPORT, and clear on return to IDLE.
REQ-023 err_cnt SHALL increment by 1 in the REPORT cycle when res_err=1, saturating at all-ones.
REQ-024 err_clr SHALL take priority over a simultaneous increment; err_cnt becomes 0.
REQ-025 Outside REPORT, res_valid, ack SHALL be 0; res_err and res_id SHALL be 0.

Reset
REQ-026 On rst_n low, asynchronously: state = IDLE, ptr = 0, grant = 0, ack = 0, busy = 0, res_valid = 0, res_err = 0, res_id = 0, err_cnt = 0, captured word = 0.
REQ-027 Reset asserted mid CHECK/REPORT SHALL abort the transaction with no result or ack emitted after release.
REQ-028 First arbitration after reset release SHALL start search at requester 0.

Structure
REQ-029 State encoding and the 5-bit word width constant SHALL live in a shared package odd_parity_pkg.
REQ-030 The parity evaluation SHALL be a sub-module odd_parity_check (5-bit in, 1-bit err out), combinational, instantiated once.
REQ-031 Arbitration (round-robin pick) SHALL be a function or block local to odd_parity_sched.

Verification
REQ-032 Reset, req=4'b0001, word[4:0]=5'b0_0001 -> res_valid at +2 cycles, res_err=0, res_id=0, ack=4'b0001, err_cnt=0.
REQ-033 req=4'b0010, word[9:5]=5'b1_0001 -> res_err=1, res_id=1, err_cnt=1.
REQ-034 req=4'b1111 held, all words valid -> res_id sequence 0,1,2,3,0, one result every 3 cycles.
REQ-035 req=4'b0100, word changed and req dropped the cycle after grant -> result reflects originally captured word, ack=4'b0100.
REQ-036 CNT_W=2, four consecutive error words -> err_cnt 1,2,3,3; err_clr coincident with an error report -> err_cnt=0.
REQ-037 rst_n pulsed low during CHECK -> no res_valid/ack, all outputs 0, next request from req=4'b1000 served with res_id=3 and ptr restarted at 0.
